// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end: state encodings,
// default bubble word and the sequential PC step.
package fetch_unit_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_ERR   = 3'd4
    } fetch_state_e;

    localparam logic [31:0] NOP_INS_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_STEP     = 32'd4;

    // Instruction addresses are word aligned; low bits of targets are dropped.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// Memory-response watchdog: counts cycles spent waiting and flags the cycle
// on which the count reaches limit-1 while still enabled.
module fetch_watchdog (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       enable,
    input  logic [7:0] limit,
    output logic       expired
);

    logic [7:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= 8'd0;
        else if (clear)
            cnt <= 8'd0;
        else if (enable)
            cnt <= cnt + 8'd1;
    end

    assign expired = enable && (cnt == limit - 8'd1);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, keeps one imem request in
// flight, buffers the returned word and presents it to the IF/ID register.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INS  = NOP_INS_DEF,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_reg,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ins_out,
    output logic [31:0] pc_out,
    output logic        fetch_valid,
    output logic        fetch_err
);

    fetch_state_e state, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  hold_ins, hold_d;
    logic         drop, drop_d;
    logic         err_q, err_d;
    logic         wd_expired;
    logic [31:0]  target;

    assign target = align_pc(redirect_pc);

    fetch_watchdog u_wd (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == S_ISSUE),
        .enable  (state == S_WAIT),
        .limit   (8'(TIMEOUT)),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            pc_q     <= RESET_PC;
            hold_ins <= NOP_INS;
            drop     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_d;
            pc_q     <= pc_d;
            hold_ins <= hold_d;
            drop     <= drop_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d     = state;
        pc_d        = pc_q;
        hold_d      = hold_ins;
        drop_d      = drop;
        err_d       = err_q;
        imem_req    = 1'b0;
        fetch_valid = 1'b0;
        case (state)
            S_IDLE: state_d = S_ISSUE;
            S_ISSUE: begin
                imem_req = !redirect_en;
                if (redirect_en)
                    pc_d = target;
                else
                    state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (drop || redirect_en) begin
                        // Wrong-path word: discard and refetch from the newest target.
                        drop_d  = 1'b0;
                        state_d = S_ISSUE;
                        if (redirect_en)
                            pc_d = target;
                    end else begin
                        hold_d  = imem_rdata;
                        state_d = S_HOLD;
                    end
                end else if (wd_expired) begin
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end else if (redirect_en) begin
                    pc_d   = target;
                    drop_d = 1'b1;
                end
            end
            S_HOLD: begin
                fetch_valid = 1'b1;
                if (redirect_en) begin
                    pc_d    = target;
                    state_d = S_ISSUE;
                end else if (en_reg) begin
                    pc_d    = pc_q + PC_STEP;
                    state_d = S_ISSUE;
                end
            end
            S_ERR: ;
            default: state_d = S_IDLE;
        endcase
    end

    assign imem_addr = pc_q;
    assign pc_out    = pc_q + PC_STEP;
    assign ins_out   = fetch_valid ? hold_ins : NOP_INS;
    assign fetch_err = err_q;

endmodule
